// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and frame-selection helper for the sprite blitter.
package sprite_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Sprite memory address layout: {frame, row, col}
    localparam int FRAME_W = 4;
    localparam int ROW_W   = 6;
    localparam int COL_W   = 6;
    localparam int ADDR_W  = FRAME_W + ROW_W + COL_W;

    localparam logic [8:0] TRANSPARENT_DEFAULT = 9'b111000111;

    typedef enum logic [2:0] {
        IDLE,
        INFO,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    // A requested frame beyond the sprite's animation range falls back to frame 0.
    // An animation-step count of 0 behaves as a single frame.
    function automatic logic [FRAME_W-1:0] effective_frame(input logic [FRAME_W-1:0] frame,
                                                           input logic [2:0]         steps);
        logic [FRAME_W-1:0] n;
        n = (steps == 3'd0) ? 4'd1 : {1'b0, steps};
        return (frame < n) ? frame : 4'd0;
    endfunction

endpackage

// File: rtl/sprite_if.sv
// Bundle of the blitter's request, sprite-memory and VGA plot signals.
interface sprite_if;
    import sprite_pkg::*;

    // Game-object side
    logic               Start;
    logic [2:0]         SpriteSel;
    logic [FRAME_W-1:0] Frame;
    logic [7:0]         PosX;
    logic [6:0]         PosY;
    logic               Busy;
    logic               Done;

    // Sprite memory side
    logic [2:0]         MemSel;
    logic [ADDR_W-1:0]  Address;
    logic [8:0]         DataIn;
    logic [COL_W-1:0]   Width;
    logic [ROW_W-1:0]   Height;
    logic [2:0]         AnimSteps;

    // VGA adapter side
    logic [7:0]         VgaX;
    logic [6:0]         VgaY;
    logic [8:0]         VgaColour;
    logic               VgaPlot;

    modport master (
        input  Start, SpriteSel, Frame, PosX, PosY,
        input  DataIn, Width, Height, AnimSteps,
        output Busy, Done, MemSel, Address,
        output VgaX, VgaY, VgaColour, VgaPlot
    );

    modport slave (
        output Start, SpriteSel, Frame, PosX, PosY,
        output DataIn, Width, Height, AnimSteps,
        input  Busy, Done, MemSel, Address,
        input  VgaX, VgaY, VgaColour, VgaPlot
    );

endinterface

// File: rtl/sprite_scan_counter.sv
// Row-major col/row walker over a width x height sprite, with a last-pixel flag.
module sprite_scan_counter
    import sprite_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic [COL_W-1:0] width,
    input  logic [ROW_W-1:0] height,
    input  logic             en,
    input  logic             clr,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_end;

    assign col_end = (col_q == width - 6'd1);
    assign last    = col_end && (row_q == height - 6'd1);
    assign col     = col_q;
    assign row     = row_q;

    // Next position: clear wins, otherwise advance one pixel when enabled
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
        end else if (en) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_q + 6'd1;
            end else begin
                col_d = col_q + 6'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: reads sprite geometry, walks the chosen frame one pixel per
// cycle, and plots every visible, non-transparent pixel at the sprite position.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int         MEM_LATENCY = 1,
    parameter logic [8:0] TRANSPARENT = TRANSPARENT_DEFAULT,
    parameter int         SCREEN_W    = sprite_pkg::SCREEN_W,
    parameter int         SCREEN_H    = sprite_pkg::SCREEN_H
)(
    input  logic     Clock,
    input  logic     Reset,
    sprite_if.master bus
);

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [7:0]         posx_q, posx_d;
    logic [6:0]         posy_q, posy_d;
    logic [COL_W-1:0]   width_q, width_d;
    logic [ROW_W-1:0]   height_q, height_d;
    logic [2:0]         drain_q, drain_d;

    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               last_pix;

    sprite_scan_counter u_scan (
        .Clock  (Clock),
        .Reset  (Reset),
        .width  (width_q),
        .height (height_q),
        .en     (state_q == SCAN),
        .clr    (state_q == INFO),
        .col    (col),
        .row    (row),
        .last   (last_pix)
    );

    // FSM next state and request/geometry latching
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        frame_d  = frame_q;
        posx_d   = posx_q;
        posy_d   = posy_q;
        width_d  = width_q;
        height_d = height_q;
        drain_d  = drain_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    sel_d   = bus.SpriteSel;
                    frame_d = bus.Frame;
                    posx_d  = bus.PosX;
                    posy_d  = bus.PosY;
                    state_d = INFO;
                end
            end
            INFO: begin
                width_d  = bus.Width;
                height_d = bus.Height;
                frame_d  = effective_frame(frame_q, bus.AnimSteps);
                if (bus.Width == '0 || bus.Height == '0) state_d = DONE;
                else                                     state_d = SCAN;
            end
            SCAN: begin
                if (last_pix) begin
                    drain_d = 3'd0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Stay MEM_LATENCY+1 cycles so the final pixel reaches the VGA register
                if (drain_q == 3'(MEM_LATENCY)) state_d = DONE;
                else                            drain_d = drain_q + 3'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and latched request registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            frame_q  <= '0;
            posx_q   <= '0;
            posy_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            frame_q  <= frame_d;
            posx_q   <= posx_d;
            posy_q   <= posy_d;
            width_q  <= width_d;
            height_q <= height_d;
            drain_q  <= drain_d;
        end
    end

    assign bus.MemSel  = (state_q == IDLE) ? 3'd0 : sel_q;
    assign bus.Address = (state_q == SCAN) ? {frame_q, row, col} : '0;
    assign bus.Busy    = (state_q != IDLE);
    assign bus.Done    = (state_q == DONE);

    // Delay line matching the memory read latency; sums are one bit wider so
    // wrap-around past the screen edge is seen as off-screen, not wrapped.
    logic       pipe_valid_q [MEM_LATENCY];
    logic [8:0] pipe_x_q     [MEM_LATENCY];
    logic [7:0] pipe_y_q     [MEM_LATENCY];
    logic       pipe_valid_d [MEM_LATENCY];
    logic [8:0] pipe_x_d     [MEM_LATENCY];
    logic [7:0] pipe_y_d     [MEM_LATENCY];

    // Shift the delay line; stage 0 takes the pixel being addressed this cycle
    always_comb begin
        pipe_valid_d[0] = (state_q == SCAN);
        pipe_x_d[0]     = {1'b0, posx_q} + {3'b000, col};
        pipe_y_d[0]     = {1'b0, posy_q} + {2'b00, row};
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_x_d[i]     = pipe_x_q[i-1];
            pipe_y_d[i]     = pipe_y_q[i-1];
        end
    end

    // Delay line registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_x_q[i]     <= '0;
                pipe_y_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_d[i];
                pipe_x_q[i]     <= pipe_x_d[i];
                pipe_y_q[i]     <= pipe_y_d[i];
            end
        end
    end

    logic [7:0] vga_x_q, vga_x_d;
    logic [6:0] vga_y_q, vga_y_d;
    logic [8:0] vga_colour_q, vga_colour_d;
    logic       vga_plot_q, vga_plot_d;

    // Clip and transparency test on the entry leaving the delay line
    always_comb begin
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        if (pipe_valid_q[MEM_LATENCY-1] &&
            bus.DataIn != TRANSPARENT &&
            pipe_x_q[MEM_LATENCY-1] < 9'(SCREEN_W) &&
            pipe_y_q[MEM_LATENCY-1] < 8'(SCREEN_H)) begin
            vga_plot_d   = 1'b1;
            vga_x_d      = pipe_x_q[MEM_LATENCY-1][7:0];
            vga_y_d      = pipe_y_q[MEM_LATENCY-1][6:0];
            vga_colour_d = bus.DataIn;
        end
    end

    // VGA output registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign bus.VgaX      = vga_x_q;
    assign bus.VgaY      = vga_y_q;
    assign bus.VgaColour = vga_colour_q;
    assign bus.VgaPlot   = vga_plot_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a one-cycle-latency sprite memory model.
module tb_sprite_blitter;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    sprite_if bus ();

    sprite_blitter #(.MEM_LATENCY(1)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Sprite memory model: geometry per sprite, pixel colour from address
    logic [5:0] w_tab [8];
    logic [5:0] h_tab [8];
    logic [2:0] s_tab [8];
    logic       solid;
    logic [5:0] tcol;

    assign bus.Width     = w_tab[bus.MemSel];
    assign bus.Height    = h_tab[bus.MemSel];
    assign bus.AnimSteps = s_tab[bus.MemSel];

    function automatic logic [8:0] colour_fn(input logic [2:0] s, input logic [15:0] a);
        if (solid) return 9'h0A5;
        if (a[5:0] == tcol) return sprite_pkg::TRANSPARENT_DEFAULT;
        return {s, a[8:6], a[2:0]};
    endfunction

    always @(posedge Clock) bus.DataIn <= colour_fn(bus.MemSel, bus.Address);

    // Cycle bookkeeping: cycle 1 is the cycle after the Start edge
    int edge_cnt = 0;
    int start_edge = 0;
    always @(posedge Clock) edge_cnt <= edge_cnt + 1;

    int plot_x [$];
    int plot_y [$];
    int plot_c [$];
    int plot_cyc [$];
    int done_n = 0;
    int done_cyc = -1;
    logic [15:0] addr_log [64];

    // Log plots, Done pulses and addresses per cycle
    always @(negedge Clock) begin
        int cy;
        cy = edge_cnt - start_edge + 1;
        if (bus.VgaPlot) begin
            plot_x.push_back(int'(bus.VgaX));
            plot_y.push_back(int'(bus.VgaY));
            plot_c.push_back(int'(bus.VgaColour));
            plot_cyc.push_back(cy);
            $display("plot cycle %0d x %0d y %0d colour %03h", cy, bus.VgaX, bus.VgaY, bus.VgaColour);
        end
        if (bus.Done) begin
            done_n++;
            done_cyc = cy;
            $display("done cycle %0d", cy);
        end
        if (cy >= 0 && cy < 64) addr_log[cy] = bus.Address;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        plot_x.delete();
        plot_y.delete();
        plot_c.delete();
        plot_cyc.delete();
        done_n = 0;
        done_cyc = -1;
    endtask

    task automatic start_draw(input logic [2:0] sel, input logic [3:0] fr,
                              input logic [7:0] x, input logic [6:0] y);
        @(negedge Clock);
        bus.SpriteSel = sel;
        bus.Frame     = fr;
        bus.PosX      = x;
        bus.PosY      = y;
        bus.Start     = 1'b1;
        start_edge    = edge_cnt + 1;
        clear_log();
        @(negedge Clock);
        bus.Start = 1'b0;
    endtask

    task automatic chk_plot(input string tag, input int k, input int x, input int y,
                            input int c, input int cy);
        if (plot_x.size() > k) begin
            chk({tag, "_x"}, plot_x[k], x);
            chk({tag, "_y"}, plot_y[k], y);
            chk({tag, "_colour"}, plot_c[k], c);
            chk({tag, "_cycle"}, plot_cyc[k], cy);
        end
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.SpriteSel = '0;
        bus.Frame = '0;
        bus.PosX = '0;
        bus.PosY = '0;
        solid = 1'b0;
        tcol = 6'h3F;
        for (int i = 0; i < 8; i++) begin
            w_tab[i] = 6'd0;
            h_tab[i] = 6'd0;
            s_tab[i] = 3'd1;
        end

        // Reset state
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("rst_busy", int'(bus.Busy), 0);
        chk("rst_done", int'(bus.Done), 0);
        chk("rst_plot", int'(bus.VgaPlot), 0);
        chk("rst_memsel", int'(bus.MemSel), 0);
        chk("rst_address", int'(bus.Address), 0);

        // 2x2 solid sprite at (10,20)
        w_tab[1] = 6'd2; h_tab[1] = 6'd2; s_tab[1] = 3'd1;
        solid = 1'b1;
        start_draw(3'd1, 4'd0, 8'd10, 7'd20);
        chk("t1_info_memsel", int'(bus.MemSel), 1);
        repeat (20) @(negedge Clock);
        chk("t1_nplots", plot_x.size(), 4);
        for (int k = 0; k < 4; k++)
            chk_plot("t1_plot", k, 10 + (k % 2), 20 + (k / 2), 9'h0A5, 4 + k);
        chk("t1_done_n", done_n, 1);
        chk("t1_done_cycle", done_cyc, 8);
        chk("t1_addr_pix2", int'(addr_log[4]), 16'h0040);
        chk("t1_idle_memsel", int'(bus.MemSel), 0);
        chk("t1_idle_busy", int'(bus.Busy), 0);

        // 3x1 sprite with transparent middle pixel
        solid = 1'b0;
        tcol = 6'd1;
        w_tab[2] = 6'd3; h_tab[2] = 6'd1; s_tab[2] = 3'd1;
        start_draw(3'd2, 4'd0, 8'd0, 7'd0);
        repeat (20) @(negedge Clock);
        chk("t2_nplots", plot_x.size(), 2);
        chk_plot("t2_plot0", 0, 0, 0, 9'h080, 4);
        chk_plot("t2_plot1", 1, 2, 0, 9'h082, 6);
        chk("t2_done_cycle", done_cyc, 7);
        tcol = 6'h3F;

        // 4x2 sprite at (158,119): only the two on-screen pixels survive
        w_tab[3] = 6'd4; h_tab[3] = 6'd2; s_tab[3] = 3'd1;
        start_draw(3'd3, 4'd0, 8'd158, 7'd119);
        repeat (25) @(negedge Clock);
        chk("t3_nplots", plot_x.size(), 2);
        chk_plot("t3_plot0", 0, 158, 119, 9'h0C0, 4);
        chk_plot("t3_plot1", 1, 159, 119, 9'h0C1, 5);
        chk("t3_done_cycle", done_cyc, 12);

        // Empty sprite
        w_tab[4] = 6'd0; h_tab[4] = 6'd3; s_tab[4] = 3'd1;
        start_draw(3'd4, 4'd0, 8'd5, 7'd5);
        repeat (10) @(negedge Clock);
        chk("t4_nplots", plot_x.size(), 0);
        chk("t4_done_cycle", done_cyc, 2);
        chk("t4_idle_memsel", int'(bus.MemSel), 0);
        chk("t4_idle_busy", int'(bus.Busy), 0);

        // Frame selection against AnimSteps
        w_tab[5] = 6'd2; h_tab[5] = 6'd1; s_tab[5] = 3'd3;
        start_draw(3'd5, 4'd5, 8'd0, 7'd0);
        repeat (15) @(negedge Clock);
        chk("t5_f5_addr0", int'(addr_log[2]), 16'h0000);
        chk("t5_f5_addr1", int'(addr_log[3]), 16'h0001);
        chk("t5_f5_done_cycle", done_cyc, 6);
        start_draw(3'd5, 4'd2, 8'd0, 7'd0);
        repeat (15) @(negedge Clock);
        chk("t5_f2_addr0", int'(addr_log[2]), 16'h2000);
        chk("t5_f2_addr1", int'(addr_log[3]), 16'h2001);
        start_draw(3'd5, 4'd3, 8'd0, 7'd0);
        repeat (15) @(negedge Clock);
        chk("t5_f3_addr1", int'(addr_log[3]), 16'h0001);
        s_tab[5] = 3'd0;
        start_draw(3'd5, 4'd1, 8'd0, 7'd0);
        repeat (15) @(negedge Clock);
        chk("t5_s0_addr1", int'(addr_log[3]), 16'h0001);

        // Reset during SCAN of an 8x8 sprite
        solid = 1'b1;
        w_tab[6] = 6'd8; h_tab[6] = 6'd8; s_tab[6] = 3'd1;
        start_draw(3'd6, 4'd0, 8'd0, 7'd0);
        repeat (8) @(negedge Clock);
        chk("t6_busy_before", int'(bus.Busy), 1);
        Reset = 1'b1;
        #1;
        chk("t6_rst_busy", int'(bus.Busy), 0);
        chk("t6_rst_plot", int'(bus.VgaPlot), 0);
        chk("t6_rst_address", int'(bus.Address), 0);
        chk("t6_rst_memsel", int'(bus.MemSel), 0);
        chk("t6_rst_vgax", int'(bus.VgaX), 0);
        clear_log();
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (80) @(negedge Clock);
        chk("t6_after_plots", plot_x.size(), 0);
        chk("t6_after_done", done_n, 0);

        // Fresh draw, with a second Start while Busy that must be ignored
        start_draw(3'd1, 4'd0, 8'd10, 7'd20);
        bus.SpriteSel = 3'd6;
        bus.PosX = 8'd50;
        bus.PosY = 7'd40;
        bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        repeat (40) @(negedge Clock);
        chk("t7_nplots", plot_x.size(), 4);
        chk_plot("t7_plot0", 0, 10, 20, 9'h0A5, 4);
        chk_plot("t7_plot3", 3, 11, 21, 9'h0A5, 7);
        chk("t7_done_n", done_n, 1);
        chk("t7_done_cycle", done_cyc, 8);
        chk("t7_idle_busy", int'(bus.Busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Sprite-drawing initiator for the sprite memory subsystem. On a start request it selects one of eight sprite memories, reads that sprite's width, height and animation-step count, then walks every pixel of the requested animation frame in row-major order. It issues one memory address per cycle and forwards each non-transparent pixel to the VGA adapter's plot port at the sprite's screen position. It sits between the game-object logic and the sprite memory / VGA adapter pair.

## Interface
Parameters:
- MEM_LATENCY, 1: cycles from Address presented to DataIn valid (1..4).
- TRANSPARENT, 9'b111000111: colour code that is never plotted.
- SCREEN_W, 160 / SCREEN_H, 120: visible plot area.

Ports:
- Clock  in  1  single system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- Start  in  1  draw request; sampled only in IDLE.
- SpriteSel  in  3  sprite memory index, latched at Start.
- Frame  in  4  requested animation frame, latched at Start.
- PosX  in  8 / PosY  in  7  screen position of the sprite's top-left pixel, latched at Start.
- MemSel  out  3  sprite memory select; held stable from INFO through DRAIN.
- Address  out  16  {frame[3:0], row[5:0], col[5:0]}.
- DataIn  in  9  pixel colour from memory.
- Width, Height  in  6 each  sprite size in pixels; 0 means empty.
- AnimSteps  in  3  number of frames; 0 is treated as 1.
- VgaX  out  8 / VgaY  out  7 / VgaColour  out  9  plot coordinates and colour.
- VgaPlot  out  1  write strobe, one pixel per cycle.
- Busy  out  1  high whenever the state is not IDLE.
- Done  out  1  one-cycle pulse at completion.

## Operation
- Reset: state IDLE. MemSel, Address, VgaX, VgaY, VgaColour, VgaPlot, Busy and Done are all 0. The pixel pipeline is cleared.
- States: IDLE -> INFO -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - Start=1 latches SpriteSel, Frame, PosX and PosY, then moves to INFO.
  - Start while Busy is ignored; it is not queued.
- INFO:
  - MemSel = latched SpriteSel.
  - Width, Height and AnimSteps are registered at the end of the cycle.
  - Effective frame = Frame if Frame < max(AnimSteps,1), else 0.
  - Width=0 or Height=0 goes straight to DONE with no plots. Otherwise go to SCAN.
- SCAN:
  - col/row counters start at 0,0 and advance one pixel per cycle.
  - col wraps at Width-1 and increments row.
  - After issuing row=Height-1, col=Width-1, go to DRAIN.
- Pixel pipeline:
  - The pipeline is MEM_LATENCY stages deep and carries valid, screen x = PosX+col and screen y = PosY+row.
  - Sums are computed 9 bits / 8 bits wide to detect overflow.
  - When a pipeline entry emerges, the Vga outputs are registered from it.
  - VgaPlot=1 only if the entry is valid, DataIn != TRANSPARENT, x < SCREEN_W and y < SCREEN_H. Out-of-screen pixels are clipped silently.
  - VgaX, VgaY and VgaColour hold their last values when VgaPlot=0.
- DRAIN: waits MEM_LATENCY+1 cycles for the pipeline to empty, then goes to DONE.
- DONE: Done=1 for one cycle, then IDLE. Start is accepted again in the cycle after DONE.
- Reset mid-operation: aborts immediately. No further VgaPlot, no Done.

## Timing
- Start sampled at edge 0. INFO occupies cycle 1. Pixel i address is presented in cycle 2+i.
- Pixel i plot (if plotted) appears in cycle 3+i+MEM_LATENCY.
- With N = Width*Height:
  - N > 0: Done is high in cycle N+MEM_LATENCY+3.
  - N = 0: Done is high in cycle 2.
- Throughput: one pixel per cycle. No stalls; the memory and the VGA adapter are always ready.

## Structure
- Package sprite_pkg:
  - SCREEN_W and SCREEN_H.
  - Address field widths: frame 4, row 6, col 6.
  - TRANSPARENT default.
  - State enum {IDLE, INFO, SCAN, DRAIN, DONE}.
- Sub-module sprite_scan_counter holds the col/row counters with wrap and last-pixel flag. Inputs: Width, Height, enable, clear.
- The top level contains the FSM, frame selection, the pixel delay line and the clip/transparency logic.

## Test plan
- 2x2 sprite, AnimSteps=1, Frame=0, Pos (10,20), all pixels 9'h0A5, MEM_LATENCY=1 -> four plots at (10,20),(11,20),(10,21),(11,21) in cycles 4-7; Done in cycle 8.
- 3x1 sprite whose middle pixel is TRANSPARENT -> plots at cols 0 and 2 only; Done timing unchanged (cycle 7).
- Pos (158,119), 4x2 sprite -> only (158,119) and (159,119) plotted; all other pixels clipped.
- Width=0 -> no VgaPlot; Done in cycle 2; MemSel returns to 0 in IDLE.
- AnimSteps=3, Frame=5 -> every Address has frame field 0. Frame=2 -> frame field 2.
- Reset asserted during SCAN of an 8x8 sprite -> outputs 0 immediately; no plots or Done afterwards; a fresh Start completes normally. A second Start during Busy is ignored.
